// File: rtl/ppe_pkg.sv
// ppe_pkg: definitions shared by the ppe_stream block and its window adder.
//   - packet field positions of the 33-bit stream word {addr, opcode, data}
//   - opcode values, default input-memory address, controller state type
//   - pack_pkt(): assembles a stream word from its three fields
package ppe_pkg;

   localparam int PKT_W    = 33;
   localparam int ADDR_MSB = 32;
   localparam int ADDR_LSB = 29;
   localparam int OP_MSB   = 28;
   localparam int OP_LSB   = 25;
   localparam int DATA_MSB = 24;

   localparam logic [3:0] OP_WEIGHT = 4'd0;
   localparam logic [3:0] OP_INPUT  = 4'd1;
   localparam logic [3:0] OP_CLEAR  = 4'd2;

   localparam logic [3:0] IMEM_ID_DEF = 4'd10;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COMPUTE  = 2'd1,
      SEND_REQ = 2'd2
   } state_t;

   function automatic logic [PKT_W-1:0] pack_pkt(input logic [3:0]  addr,
                                                  input logic [3:0]  opcode,
                                                  input logic [24:0] data);
      return {addr, opcode, data};
   endfunction

endpackage

// File: rtl/ppe_stream_if.sv
// ppe_stream_if: one valid/ready stream channel carrying 33-bit packets.
//   data  : packet {addr[32:29], opcode[28:25], data[24:0]}
//   valid : producer has a packet on data
//   ready : consumer accepts; a transfer happens when valid & ready at clk rise
//   master modport = producer side, slave modport = consumer side
interface ppe_stream_if;
   import ppe_pkg::*;

   logic [PKT_W-1:0] data;
   logic             valid;
   logic             ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/ppe_window_sum.sv
// ppe_window_sum: combinational partial sum of one sliding window.
//   bits    : FILTER_SIZE 1-bit inputs of the window (bit w pairs with tap w)
//   weights : one filter row, tap w in weights[w*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   psum    : signed sum of the taps whose input bit is set
module ppe_window_sum #(
   parameter int FILTER_SIZE  = 5,
   parameter int WEIGHT_WIDTH = 8
) (
   input  logic [FILTER_SIZE-1:0]                             bits,
   input  logic [FILTER_SIZE*WEIGHT_WIDTH-1:0]                weights,
   output logic signed [WEIGHT_WIDTH+$clog2(FILTER_SIZE)-1:0] psum
);

   localparam int PSUM_W = WEIGHT_WIDTH + $clog2(FILTER_SIZE);

   always_comb begin
      psum = '0;
      for (int w = 0; w < FILTER_SIZE; w++) begin
         if (bits[w]) begin
            psum = psum + PSUM_W'($signed(weights[w*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
         end
      end
   end

endmodule

// File: rtl/ppe_stream.sv
// ppe_stream: binary-input convolution PE on a packet stream.
//   clk    : single clock, all state changes on its rising edge
//   rst    : asynchronous active-high reset
//   in_ch  : slave stream; WEIGHT / INPUT / CLEAR packets in
//   out_ch : master stream; psum packets, then one input-memory request
//   err    : sticky protocol-error flag, cleared only by rst
// A loaded INPUT row produces NUM_FILTERS*(IFMAP_SIZE-FILTER_SIZE+1) psums
// (filter-major, window ascending), one per handshake, followed by a request
// packet to IMEM_ID.
module ppe_stream
   import ppe_pkg::*;
#(
   parameter int FILTER_SIZE     = 5,
   parameter int IFMAP_SIZE      = 25,
   parameter int NUM_FILTERS     = 2,
   parameter int WEIGHT_WIDTH    = 8,
   parameter int WEIGHTS_PER_PKT = 3,
   parameter int NUM_DEST        = 5,
   parameter int IMEM_ID         = int'(IMEM_ID_DEF)
) (
   input  logic         clk,
   input  logic         rst,
   ppe_stream_if.slave  in_ch,
   ppe_stream_if.master out_ch,
   output logic         err
);

   localparam int CAP    = NUM_FILTERS * FILTER_SIZE;
   localparam int NWIN   = IFMAP_SIZE - FILTER_SIZE + 1;
   localparam int PSUM_W = WEIGHT_WIDTH + $clog2(FILTER_SIZE);
   localparam int PTR_W  = $clog2(CAP + 1);
   localparam int F_W    = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam int J_W    = (NWIN > 1) ? $clog2(NWIN) : 1;
   localparam int D_W    = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;

   state_t state, state_nxt;

   logic                           rdy_en;
   logic [PTR_W-1:0]               wptr;
   logic                           loaded;
   logic signed [WEIGHT_WIDTH-1:0] wmem [0:(1<<PTR_W)-1];
   logic [IFMAP_SIZE-1:0]          ifmap;
   logic [F_W-1:0]                 f_cnt;
   logic [J_W-1:0]                 j_cnt;
   logic [D_W-1:0]                 d_cnt;

   logic [3:0]                     in_addr;
   logic [3:0]                     in_op;
   logic [DATA_MSB:0]              in_pay;
   logic                           in_fire, out_fire, last_psum;
   logic                           wr_en, start_row, bad_pkt;
   logic [FILTER_SIZE-1:0]         win;
   logic [FILTER_SIZE*WEIGHT_WIDTH-1:0] wrow;
   logic signed [PSUM_W-1:0]       psum;

   function automatic logic [DATA_MSB:0] sext_psum(input logic signed [PSUM_W-1:0] p);
      return (DATA_MSB+1)'(p);
   endfunction

   assign in_addr   = in_ch.data[ADDR_MSB:ADDR_LSB];
   assign in_op     = in_ch.data[OP_MSB:OP_LSB];
   assign in_pay    = in_ch.data[DATA_MSB:0];
   assign in_fire   = in_ch.valid & in_ch.ready;
   assign out_fire  = out_ch.valid & out_ch.ready;
   assign last_psum = (f_cnt == F_W'(NUM_FILTERS-1)) && (j_cnt == J_W'(NWIN-1));

   assign wr_en     = in_fire && (in_op == OP_WEIGHT) && !loaded;
   assign start_row = in_fire && (in_op == OP_INPUT) && loaded;
   assign bad_pkt   = in_fire && (((in_op == OP_WEIGHT) && loaded) ||
                                  ((in_op == OP_INPUT) && !loaded) ||
                                  ((in_op != OP_WEIGHT) && (in_op != OP_INPUT) &&
                                   (in_op != OP_CLEAR)));

   // controller: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // controller: next state and handshake outputs
   always_comb begin
      state_nxt    = state;
      in_ch.ready  = 1'b0;
      out_ch.valid = 1'b0;
      case (state)
         IDLE: begin
            in_ch.ready = rdy_en;
            if (start_row) state_nxt = COMPUTE;
         end
         COMPUTE: begin
            out_ch.valid = 1'b1;
            if (out_fire && last_psum) state_nxt = SEND_REQ;
         end
         SEND_REQ: begin
            out_ch.valid = 1'b1;
            if (out_fire) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // control registers: ready enable, weight pointer, row counters, error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en <= 1'b0;
         wptr   <= '0;
         loaded <= 1'b0;
         f_cnt  <= '0;
         j_cnt  <= '0;
         d_cnt  <= '0;
         err    <= 1'b0;
      end else begin
         // ready only comes up on the first edge after reset release
         rdy_en <= 1'b1;
         if (bad_pkt) err <= 1'b1;
         if (in_fire && (in_op == OP_CLEAR)) begin
            wptr   <= '0;
            loaded <= 1'b0;
         end else if (wr_en) begin
            if (int'(wptr) + WEIGHTS_PER_PKT >= CAP) begin
               wptr   <= PTR_W'(CAP);
               loaded <= 1'b1;
            end else begin
               wptr <= wptr + PTR_W'(WEIGHTS_PER_PKT);
            end
         end
         if (start_row) begin
            f_cnt <= '0;
            j_cnt <= '0;
            d_cnt <= D_W'(int'(in_addr) % NUM_DEST);
         end else if ((state == COMPUTE) && out_fire) begin
            d_cnt <= (d_cnt == D_W'(NUM_DEST-1)) ? '0 : d_cnt + 1'b1;
            if (j_cnt == J_W'(NWIN-1)) begin
               j_cnt <= '0;
               f_cnt <= last_psum ? '0 : f_cnt + 1'b1;
            end else begin
               j_cnt <= j_cnt + 1'b1;
            end
         end
      end
   end

   // data registers: weight memory and latched input row (no reset needed)
   always_ff @(posedge clk) begin
      if (start_row) ifmap <= in_pay[IFMAP_SIZE-1:0];
      if (wr_en) begin
         for (int k = 0; k < WEIGHTS_PER_PKT; k++) begin
            // taps past capacity in the filling packet are dropped
            if (int'(wptr) + k < CAP) begin
               wmem[PTR_W'(int'(wptr) + k)] <= in_pay[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
         end
      end
   end

   // window select and weight row gather for the current (filter, window)
   always_comb begin
      win  = FILTER_SIZE'(ifmap >> j_cnt);
      wrow = '0;
      for (int w = 0; w < FILTER_SIZE; w++) begin
         wrow[w*WEIGHT_WIDTH +: WEIGHT_WIDTH] = wmem[PTR_W'(int'(f_cnt)*FILTER_SIZE + w)];
      end
   end

   ppe_window_sum #(
      .FILTER_SIZE  (FILTER_SIZE),
      .WEIGHT_WIDTH (WEIGHT_WIDTH)
   ) u_window_sum (
      .bits    (win),
      .weights (wrow),
      .psum    (psum)
   );

   // output word is a function of held state, so it stays stable under stall
   always_comb begin
      out_ch.data = '0;
      case (state)
         COMPUTE:  out_ch.data = pack_pkt(4'(d_cnt), OP_WEIGHT, sext_psum(psum));
         SEND_REQ: out_ch.data = pack_pkt(4'(IMEM_ID), 4'd0, '0);
         default:  out_ch.data = '0;
      endcase
   end

endmodule

// File: tb/tb_ppe_stream.sv
// tb_ppe_stream: directed bench for ppe_stream with default parameters.
module tb_ppe_stream;

   logic clk;
   logic rst;
   logic err;

   ppe_stream_if in_bus();
   ppe_stream_if out_bus();

   ppe_stream dut (
      .clk    (clk),
      .rst    (rst),
      .in_ch  (in_bus),
      .out_ch (out_bus),
      .err    (err)
   );

   int n_chk = 0;
   int n_bad = 0;
   logic [32:0] outq [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // record every packet that will transfer on the coming rising edge
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (out_bus.valid && out_bus.ready) outq.push_back(out_bus.data);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic send_pkt(input logic [3:0] a, input logic [3:0] op, input logic [24:0] d);
      int t;
      t = 0;
      @(negedge clk);
      in_bus.data  = {a, op, d};
      in_bus.valid = 1'b1;
      while (!in_bus.ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("in_ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
      in_bus.valid = 1'b0;
      in_bus.data  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // f0 taps all +1, f1 taps all -1; last packet carries two surplus weights
   task automatic load_ones();
      send_pkt(4'd0, 4'd0, 25'h0010101);
      send_pkt(4'd0, 4'd0, 25'h0FF0101);
      send_pkt(4'd0, 4'd0, 25'h0FFFFFF);
      send_pkt(4'd0, 4'd0, 25'h07777FF);
   endtask

   // e0/e1: f0 psum at even/odd window, e2/e3: f1 psum at even/odd window
   task automatic check_row(input string tag, input int base,
                            input int e0, input int e1, input int e2, input int e3);
      int t;
      int ev;
      logic [24:0] pd;
      logic [63:0] got;
      logic [63:0] exp;
      t = 0;
      while (outq.size() < 43 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) chk({tag, "_timeout"}, 64'(outq.size()), 64'd43);
      repeat (5) @(negedge clk);
      #3;
      chk({tag, "_count"}, 64'(outq.size()), 64'd43);
      for (int n = 0; n < 43; n++) begin
         if (n < 42) begin
            if (n < 21) ev = (n % 2 == 0) ? e0 : e1;
            else        ev = ((n - 21) % 2 == 0) ? e2 : e3;
            pd  = 25'(ev);
            exp = 64'({4'((base + n) % 5), 4'd0, pd});
         end else begin
            exp = 64'({4'd10, 4'd0, 25'd0});
         end
         got = (n < outq.size()) ? 64'(outq[n]) : 64'hFFFF_FFFF_FFFF_FFFF;
         chk($sformatf("%s_pkt%0d", tag, n), got, exp);
      end
   endtask

   initial begin
      int t;
      logic [32:0] hold;
      rst            = 1'b1;
      in_bus.valid   = 1'b0;
      in_bus.data    = '0;
      out_bus.ready  = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", 64'(in_bus.ready), 64'd0);
      chk("rst_out_valid", 64'(out_bus.valid), 64'd0);
      chk("rst_out_data", 64'(out_bus.data), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      rst = 1'b0;
      #1;
      chk("rel_in_ready_before_edge", 64'(in_bus.ready), 64'd0);
      @(negedge clk);
      chk("rel_in_ready_after_edge", 64'(in_bus.ready), 64'd1);

      // all-ones input row, full throughput
      load_ones();
      outq.delete();
      send_pkt(4'd0, 4'd1, 25'h1FFFFFF);
      #1;
      chk("first_valid", 64'(out_bus.valid), 64'd1);
      repeat (42) @(negedge clk);
      #3;
      chk("throughput_cnt", 64'(outq.size()), 64'd43);
      check_row("ones", 0, 5, 5, -5, -5);
      chk("ones_err", 64'(err), 64'd0);

      // alternating input row, base address 3
      outq.delete();
      send_pkt(4'd3, 4'd1, 25'h1555555);
      check_row("alt", 3, 3, 2, -3, -2);

      // back-pressure in mid-row
      outq.delete();
      send_pkt(4'd1, 4'd1, 25'h1FFFFFF);
      t = 0;
      while (outq.size() < 9 && t < 200) begin
         @(negedge clk);
         t++;
      end
      out_bus.ready = 1'b0;
      #3;
      hold = out_bus.data;
      chk("stall_valid", 64'(out_bus.valid), 64'd1);
      repeat (9) begin
         @(negedge clk);
         #3;
         chk("stall_hold", 64'(out_bus.data), 64'(hold));
      end
      @(negedge clk);
      out_bus.ready = 1'b1;
      #1;
      chk("stall_hold_last", 64'(out_bus.data), 64'(hold));
      check_row("stall", 1, 5, 5, -5, -5);

      // reset after the 7th psum abandons the row
      outq.delete();
      send_pkt(4'd0, 4'd1, 25'h1FFFFFF);
      t = 0;
      while (outq.size() < 7 && t < 200) begin
         @(negedge clk);
         t++;
      end
      rst = 1'b1;
      #3;
      chk("midrst_out_valid", 64'(out_bus.valid), 64'd0);
      chk("midrst_out_data", 64'(out_bus.data), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      #3;
      chk("midrst_no_more_out", 64'(outq.size()), 64'd7);
      chk("midrst_err", 64'(err), 64'd0);

      // INPUT with no weights loaded
      send_pkt(4'd0, 4'd1, 25'h1FFFFFF);
      repeat (10) @(negedge clk);
      #3;
      chk("noload_err", 64'(err), 64'd1);
      chk("noload_no_out", 64'(outq.size()), 64'd7);
      chk("noload_in_ready", 64'(in_bus.ready), 64'd1);

      // reload and rerun the row
      load_ones();
      outq.delete();
      send_pkt(4'd0, 4'd1, 25'h1FFFFFF);
      check_row("reload", 0, 5, 5, -5, -5);

      // WEIGHT packet into a full memory
      do_reset();
      @(negedge clk);
      chk("rst2_err", 64'(err), 64'd0);
      load_ones();
      #1;
      chk("full_load_err", 64'(err), 64'd0);
      send_pkt(4'd0, 4'd0, 25'h0010101);
      #1;
      chk("overfill_err", 64'(err), 64'd1);

      // CLEAR then new weights: f0 = 1,2,3,4,5, f1 all -1
      send_pkt(4'd0, 4'd2, 25'h0);
      send_pkt(4'd0, 4'd0, 25'h0030201);
      send_pkt(4'd0, 4'd0, 25'h0FF0504);
      send_pkt(4'd0, 4'd0, 25'h0FFFFFF);
      send_pkt(4'd0, 4'd0, 25'h00000FF);
      outq.delete();
      send_pkt(4'd2, 4'd1, 25'h1FFFFFF);
      check_row("clear", 2, 15, 15, -5, -5);

      // unknown opcode
      do_reset();
      @(negedge clk);
      chk("rst3_err", 64'(err), 64'd0);
      send_pkt(4'd0, 4'd7, 25'h1234);
      #1;
      chk("badop_err", 64'(err), 64'd1);
      chk("badop_in_ready", 64'(in_bus.ready), 64'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/ppe_stream.md
PPE_STREAM -- requirements
Module: ppe_stream

Interface
REQ-001 Parameter FILTER_SIZE, default 5, meaning weights per filter row and sliding-window width.
REQ-002 Parameter IFMAP_SIZE, default 25, meaning 1-bit inputs per input row; SHALL be <= 25.
REQ-003 Parameter NUM_FILTERS, default 2, meaning independent weight banks evaluated per input row.
REQ-004 Parameter WEIGHT_WIDTH, default 8, meaning signed weight width.
REQ-005 Parameter WEIGHTS_PER_PKT, default 3, meaning weights per WEIGHT packet; WEIGHTS_PER_PKT*WEIGHT_WIDTH SHALL be <= 25.
REQ-006 Parameters NUM_DEST, default 5, meaning number of summing PEs cycled through, and IMEM_ID, default 10, meaning input-memory address.
REQ-007 Port clk, input, 1, meaning single clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1, meaning asynchronous active-high reset.
REQ-009 Ports in_data, input, 33, packet {addr[32:29], opcode[28:25], data[24:0]}; in_valid, input, 1; in_ready, output, 1.
REQ-010 Ports out_data, output, 33, packet in the same format; out_valid, output, 1; out_ready, input, 1.
REQ-011 Port err, output, 1, meaning sticky protocol-error flag.

Function
REQ-012 A transfer on either channel SHALL occur only in a cycle where valid and ready are both high at the rising clk edge.
REQ-013 States SHALL be IDLE, COMPUTE, SEND_REQ; in_ready SHALL be high only in IDLE.
REQ-014 Opcodes SHALL be 0 WEIGHT, 1 INPUT, 2 CLEAR; any other opcode SHALL be accepted, dropped, and SHALL set err.
REQ-015 WEIGHT: weight k SHALL be data[k*WEIGHT_WIDTH +: WEIGHT_WIDTH], k = 0..WEIGHTS_PER_PKT-1, written at the linear pointer (filter-major, then tap) and incremented.
REQ-016 Weights beyond capacity NUM_FILTERS*FILTER_SIZE within the packet that fills the memory SHALL be discarded silently.
REQ-017 A WEIGHT packet arriving with the memory already full SHALL be dropped and SHALL set err.
REQ-018 CLEAR SHALL reset the weight pointer and the loaded flag; weight contents need not be cleared.
REQ-019 INPUT with weights not fully loaded SHALL be dropped, set err, and produce no output.
REQ-020 INPUT with weights loaded SHALL latch data[IFMAP_SIZE-1:0] and base address addr, then enter COMPUTE.
REQ-021 COMPUTE SHALL emit NUM_FILTERS*(IFMAP_SIZE-FILTER_SIZE+1) packets, filter-major, window j ascending; psum(f,j) = sum over w of in[j+w] ? weight[f][w] : 0.
REQ-022 psum SHALL be signed, width WEIGHT_WIDTH+$clog2(FILTER_SIZE), sign-extended into data[24:0]; opcode SHALL be 0.
REQ-023 Output addr for the n-th psum (n from 0 within the row) SHALL be (base + n) mod NUM_DEST, 4 bits.
REQ-024 The first out_valid SHALL rise in the cycle after INPUT acceptance; each subsequent psum SHALL be presented in the cycle after the previous handshake (one per cycle at full throughput).
REQ-025 While out_valid is high and out_ready is low, out_data SHALL be held stable.
REQ-026 After the last psum handshake the block SHALL enter SEND_REQ and present {IMEM_ID, 0, 0}; on its handshake it SHALL return to IDLE.
REQ-027 err SHALL stay high until reset.

Reset
REQ-028 rst high SHALL immediately force IDLE, out_valid 0, out_data 0, err 0, weight pointer 0, loaded flag 0, window/filter counters 0.
REQ-029 in_ready SHALL be 0 while rst is high and 1 from the first clk edge after rst falls.
REQ-030 Reset during COMPUTE or SEND_REQ SHALL abandon the row with no further output, including no IMEM request.

Structure
REQ-031 Opcode constants, packet field bit positions, IMEM_ID default and state enum SHALL live in shared package ppe_pkg.
REQ-032 The window adder SHALL be sub-module ppe_window_sum (inputs: FILTER_SIZE bits, one weight row; output: psum), purely combinational.

Verification (FILTER_SIZE 5, IFMAP_SIZE 25, NUM_FILTERS 2, WEIGHT_WIDTH 8, WEIGHTS_PER_PKT 3, NUM_DEST 5)
REQ-033 Four WEIGHT packets (f0 all 1, f1 all 8'hFF), then INPUT data 25'h1FFFFFF, addr 0 -> 21 psums of 5, then 21 of -5, addresses 0,1,2,3,4,0,...; then one packet {10,0,0}; err stays 0.
REQ-034 Same weights, INPUT 25'h1555555 -> f0 psums alternate 3,2 starting j=0; f1 alternates -3,-2; 43 output packets total.
REQ-035 out_ready held low for 10 cycles mid-row -> out_data unchanged for all 10 cycles, no psum lost or duplicated.
REQ-036 INPUT before any WEIGHT -> err=1, no output, in_ready stays 1; fifth WEIGHT after full load -> err=1.
REQ-037 rst pulsed after the 7th psum -> outputs stop, no IMEM request; reload weights, resend INPUT -> full correct 43-packet sequence.
REQ-038 CLEAR, then new weights (f0 = 1,2,3,4,5), INPUT 25'h1FFFFFF -> f0 psums all 15.
